// File: rtl/cv32e40p_core_v_xif_pkg.sv
// CORE-V-XIF shared types for the coprocessor result path.
package cv32e40p_core_v_xif_pkg;

    localparam int unsigned X_ID_WIDTH = 4;

    typedef struct packed {
        logic [X_ID_WIDTH-1:0] id;
        logic [31:0]           data;
        logic [4:0]            rd;
        logic                  we;
    } x_result_entry_t;

endpackage

// File: rtl/cv32e40p_x_result_buffer.sv
// In-order buffer for coprocessor results, presented to EX when the ALU write
// port is idle, or forced when the buffer is full, starved or the result never writes.
module cv32e40p_x_result_buffer
    import cv32e40p_core_v_xif_pkg::*;
#(
    parameter int unsigned DEPTH        = 2,
    parameter int unsigned X_ID_WIDTH   = cv32e40p_core_v_xif_pkg::X_ID_WIDTH,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        x_result_valid_i,
    output logic                        x_result_ready_o,
    input  logic [X_ID_WIDTH-1:0]       x_result_id_i,
    input  logic [31:0]                 x_result_data_i,
    input  logic [4:0]                  x_result_rd_i,
    input  logic                        x_result_we_i,
    input  logic                        alu_wb_req_i,
    output logic                        x_result_valid_assigned_o,
    output logic [X_ID_WIDTH-1:0]       x_result_id_o,
    output logic [31:0]                 x_result_data_o,
    output logic [4:0]                  x_result_rd_o,
    output logic                        x_result_we_o,
    output logic [31:0]                 rd_busy_o,
    output logic [$clog2(DEPTH+1)-1:0]  count_o
);

    localparam int unsigned CW  = $clog2(DEPTH + 1);
    localparam int unsigned PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned SW  = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned PIW = cv32e40p_core_v_xif_pkg::X_ID_WIDTH;

    x_result_entry_t        mem_q [DEPTH];
    x_result_entry_t        mem_d [DEPTH];
    logic [PW-1:0]          wptr_q, wptr_d;
    logic [PW-1:0]          rptr_q, rptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic [SW-1:0]          starve_q, starve_d;

    x_result_entry_t        head;
    x_result_entry_t        in_entry;
    logic                   empty;
    logic                   force_pop;
    logic                   push;
    logic                   pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty    = (count_q == '0);
    assign head     = mem_q[rptr_q];

    assign in_entry.id   = PIW'(x_result_id_i);
    assign in_entry.data = x_result_data_i;
    assign in_entry.rd   = x_result_rd_i;
    assign in_entry.we   = x_result_we_i;

    // Ready is purely registered; a pop in the same cycle does not free a slot early.
    assign x_result_ready_o = (count_q < CW'(DEPTH));
    assign push             = x_result_valid_i & x_result_ready_o;

    assign force_pop = (count_q == CW'(DEPTH)) | ~head.we | (head.rd == 5'd0)
                     | (starve_q >= SW'(STARVE_LIMIT));
    assign pop       = ~empty & (force_pop | ~alu_wb_req_i);

    assign x_result_valid_assigned_o = pop;
    assign x_result_id_o             = empty ? '0 : X_ID_WIDTH'(head.id);
    assign x_result_data_o           = empty ? '0 : head.data;
    assign x_result_rd_o             = empty ? '0 : head.rd;
    assign x_result_we_o             = empty ? 1'b0 : head.we;
    assign count_o                   = count_q;

    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push) begin
            mem_d[wptr_q] = in_entry;
            wptr_d        = ptr_inc(wptr_q);
        end
        if (pop) begin
            rptr_d = ptr_inc(rptr_q);
        end
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        starve_d = starve_q;
        if (pop || empty) begin
            starve_d = '0;
        end else if (alu_wb_req_i && (starve_q < SW'(STARVE_LIMIT))) begin
            starve_d = starve_q + 1'b1;
        end
    end

    // Walk the occupied slots from the head; only real register writes mark busy.
    always_comb begin
        x_result_entry_t e;
        rd_busy_o = '0;
        e         = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (k < int'(count_q)) begin
                e = mem_q[PW'((int'(rptr_q) + k) % DEPTH)];
                if (e.we && (e.rd != 5'd0)) begin
                    rd_busy_o[e.rd] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            starve_q <= '0;
        end else begin
            mem_q    <= mem_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
        end
    end

endmodule

// File: tb/tb_cv32e40p_x_result_buffer.sv
// Directed bench for the coprocessor result buffer (DEPTH=2, STARVE_LIMIT=4).
module tb_cv32e40p_x_result_buffer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        x_result_valid_i = 1'b0;
    logic        x_result_ready_o;
    logic [3:0]  x_result_id_i = '0;
    logic [31:0] x_result_data_i = '0;
    logic [4:0]  x_result_rd_i = '0;
    logic        x_result_we_i = 1'b0;
    logic        alu_wb_req_i = 1'b0;
    logic        x_result_valid_assigned_o;
    logic [3:0]  x_result_id_o;
    logic [31:0] x_result_data_o;
    logic [4:0]  x_result_rd_o;
    logic        x_result_we_o;
    logic [31:0] rd_busy_o;
    logic [1:0]  count_o;

    int n_chk  = 0;
    int n_pass = 0;

    cv32e40p_x_result_buffer #(.DEPTH(2), .X_ID_WIDTH(4), .STARVE_LIMIT(4)) dut (
        .clk                       (clk),
        .rst_n                     (rst_n),
        .x_result_valid_i          (x_result_valid_i),
        .x_result_ready_o          (x_result_ready_o),
        .x_result_id_i             (x_result_id_i),
        .x_result_data_i           (x_result_data_i),
        .x_result_rd_i             (x_result_rd_i),
        .x_result_we_i             (x_result_we_i),
        .alu_wb_req_i              (alu_wb_req_i),
        .x_result_valid_assigned_o (x_result_valid_assigned_o),
        .x_result_id_o             (x_result_id_o),
        .x_result_data_o           (x_result_data_o),
        .x_result_rd_o             (x_result_rd_o),
        .x_result_we_o             (x_result_we_o),
        .rd_busy_o                 (rd_busy_o),
        .count_o                   (count_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] id, input logic [4:0] rd,
                         input logic we, input logic [31:0] data);
        x_result_valid_i = v;
        x_result_id_i    = id;
        x_result_rd_i    = rd;
        x_result_we_i    = we;
        x_result_data_i  = data;
    endtask

    initial begin
        // reset state
        #12;
        chk("rst_ready", 32'(x_result_ready_o), 1);
        chk("rst_assigned", 32'(x_result_valid_assigned_o), 0);
        chk("rst_busy", rd_busy_o, 0);
        chk("rst_count", 32'(count_o), 0);
        chk("rst_data", x_result_data_o, 0);
        chk("rst_rd", 32'(x_result_rd_o), 0);
        chk("rst_id", 32'(x_result_id_o), 0);
        chk("rst_we", 32'(x_result_we_o), 0);
        rst_n = 1'b1;
        step();

        // single result, idle EX
        alu_wb_req_i = 1'b0;
        drive(1, 4'd3, 5'd5, 1, 32'hDEADBEEF);
        #1;
        chk("single_no_bypass", 32'(x_result_valid_assigned_o), 0);
        step();
        drive(0, 0, 0, 0, 0);
        #1;
        chk("single_assigned", 32'(x_result_valid_assigned_o), 1);
        chk("single_rd", 32'(x_result_rd_o), 5);
        chk("single_data", x_result_data_o, 32'hDEADBEEF);
        chk("single_id", 32'(x_result_id_o), 3);
        chk("single_busy", rd_busy_o, 32'h0000_0020);
        step();
        chk("single_count_after", 32'(count_o), 0);
        chk("single_busy_after", rd_busy_o, 0);

        // starvation: head waits exactly STARVE_LIMIT cycles
        alu_wb_req_i = 1'b1;
        drive(1, 4'd6, 5'd6, 1, 32'h1234_5678);
        step();
        drive(0, 0, 0, 0, 0);
        for (int c = 1; c <= 5; c++) begin
            #1;
            chk($sformatf("starve_c%0d", c), 32'(x_result_valid_assigned_o), (c == 5) ? 1 : 0);
            if (c == 1) chk("starve_busy", rd_busy_o, 32'h0000_0040);
            step();
        end
        chk("starve_popped", 32'(count_o), 0);

        // full forcing with alu busy
        alu_wb_req_i = 1'b1;
        drive(1, 4'd1, 5'd8, 1, 32'hA);
        step();
        drive(1, 4'd2, 5'd9, 1, 32'hB);
        step();
        drive(1, 4'd3, 5'd10, 1, 32'hC);
        #1;
        chk("full_ready", 32'(x_result_ready_o), 0);
        chk("full_count", 32'(count_o), 2);
        chk("full_forced", 32'(x_result_valid_assigned_o), 1);
        chk("full_head_id", 32'(x_result_id_o), 1);
        chk("full_busy", rd_busy_o, 32'h0000_0300);
        step();
        chk("full_after_pop_count", 32'(count_o), 1);
        chk("full_after_pop_ready", 32'(x_result_ready_o), 1);
        chk("full_after_pop_id", 32'(x_result_id_o), 2);
        chk("full_after_pop_assigned", 32'(x_result_valid_assigned_o), 0);
        step();
        drive(0, 0, 0, 0, 0);
        #1;
        chk("full_third_accepted", 32'(count_o), 2);
        chk("full_refull_forced", 32'(x_result_valid_assigned_o), 1);
        chk("full_refull_id", 32'(x_result_id_o), 2);
        chk("full_refull_busy", rd_busy_o, 32'h0000_0600);
        step();
        alu_wb_req_i = 1'b0;
        #1;
        chk("full_drain_id", 32'(x_result_id_o), 3);
        chk("full_drain_assigned", 32'(x_result_valid_assigned_o), 1);
        step();
        chk("full_drained", 32'(count_o), 0);

        // no-write results pop at once even with alu busy
        alu_wb_req_i = 1'b1;
        drive(1, 4'd4, 5'd7, 0, 32'h7);
        step();
        drive(1, 4'd5, 5'd0, 1, 32'h8);
        #1;
        chk("nowr_we0_assigned", 32'(x_result_valid_assigned_o), 1);
        chk("nowr_we0_id", 32'(x_result_id_o), 4);
        chk("nowr_we0_busy", rd_busy_o, 0);
        step();
        drive(0, 0, 0, 0, 0);
        #1;
        chk("nowr_rd0_assigned", 32'(x_result_valid_assigned_o), 1);
        chk("nowr_rd0_id", 32'(x_result_id_o), 5);
        chk("nowr_rd0_busy", rd_busy_o, 0);
        step();
        chk("nowr_count", 32'(count_o), 0);
        chk("nowr_busy_end", rd_busy_o, 0);

        // streaming with simultaneous push/pop and pointer wrap
        alu_wb_req_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(1, 4'(i), 5'(i + 1), 1, 32'(i * 32'h11));
            #1;
            chk($sformatf("stream_count_%0d", i), 32'(count_o), (i > 0) ? 1 : 0);
            if (i > 0) begin
                chk($sformatf("stream_id_%0d", i - 1), 32'(x_result_id_o), 32'(i - 1));
                chk($sformatf("stream_data_%0d", i - 1), x_result_data_o, 32'((i - 1) * 32'h11));
                chk($sformatf("stream_assigned_%0d", i - 1), 32'(x_result_valid_assigned_o), 1);
            end
            step();
        end
        drive(0, 0, 0, 0, 0);
        #1;
        chk("stream_id_5", 32'(x_result_id_o), 5);
        chk("stream_assigned_5", 32'(x_result_valid_assigned_o), 1);
        step();
        chk("stream_empty", 32'(count_o), 0);

        // asynchronous reset with two entries held
        alu_wb_req_i = 1'b1;
        drive(1, 4'd9, 5'd11, 1, 32'h11);
        step();
        drive(1, 4'd10, 5'd12, 1, 32'h12);
        step();
        drive(0, 0, 0, 0, 0);
        #1;
        chk("prerst_count", 32'(count_o), 2);
        chk("prerst_busy", rd_busy_o, 32'h0000_1800);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_count", 32'(count_o), 0);
        chk("arst_assigned", 32'(x_result_valid_assigned_o), 0);
        chk("arst_busy", rd_busy_o, 0);
        chk("arst_ready", 32'(x_result_ready_o), 1);
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_count", 32'(count_o), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
